// File: rtl/dmem_bridge_if.sv
// Bus bundle between the core data port, the bridge and the external data memory.
// The bridge takes the slave view; whoever drives the core strobes and answers
// the memory handshake (a core model, a testbench) takes the master view.
interface dmem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core side
  logic              cs;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              err;
  // memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cs, rd, wr, addr, wdata, mem_ack, mem_rdata,
    output rdata, stall, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cs, rd, wr, addr, wdata, mem_ack, mem_rdata,
    input  rdata, stall, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns each single-cycle core access into a req/ack
// handshake with a slow memory, stalling the core until the access is done.
// Misaligned accesses and memory timeouts complete without data and pulse err.
module dmem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  dmem_bridge_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic access;
  logic misaligned;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  assign access     = bus.cs & (bus.rd | bus.wr);
  assign misaligned = (bus.addr[1:0] != 2'b00);

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            // Complete immediately without touching the memory bus.
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            // Core inputs are only sampled here; the bus holds them until done.
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.wr;
            mem_addr_d  = word_align(bus.addr);
            mem_wdata_d = bus.wdata;
            cnt_d       = '0;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) rdata_d = bus.mem_rdata;
        end else if (cnt_q == CNT_MAX) begin
          // Memory never answered: abort and hand the core a poison value.
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we_q) rdata_d = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Stall is combinational so the core freezes in the same cycle it issues an access.
  assign bus.stall     = ((state_q == IDLE) & access) | (state_q == BUSY);
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge: directed scenarios plus randomized accesses,
// checked against a transaction-level model of the bridge.
module tb_dmem_bridge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int MAX_CYC = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_rdata = '0;

  // One core instruction. Called at a falling edge while the bridge is idle;
  // returns at the falling edge of the cycle after the instruction completed.
  // ack_after: BUSY cycle index (0 = first) in which memory acks, -1 = never.
  task automatic do_access(input string name, input logic c, input logic r, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input int ack_after, input logic [DATA_W-1:0] ack_data,
                           input bit ack_in_done);
    bit acc, mis, done;
    int eff, exp_stall, exp_req, exp_first, cyc, stall_cnt, req_cnt, first_req, err_early;
    logic exp_err, got_err;
    logic [DATA_W-1:0] exp_rdata, got_rdata;
    logic [ADDR_W-1:0] exp_addr;
    acc = c & (r | w);
    mis = (a[1:0] != 2'b00);
    eff = (ack_after >= 0 && ack_after < TIMEOUT) ? ack_after : -1;
    exp_addr = {a[ADDR_W-1:2], 2'b00};
    if (!acc) begin
      exp_stall = 0; exp_req = 0; exp_err = 1'b0; exp_rdata = model_rdata;
    end else if (mis) begin
      exp_stall = 1; exp_req = 0; exp_err = 1'b1; exp_rdata = model_rdata;
    end else if (eff >= 0) begin
      exp_stall = eff + 2; exp_req = eff + 1; exp_err = 1'b0;
      exp_rdata = w ? model_rdata : ack_data;
    end else begin
      exp_stall = TIMEOUT + 1; exp_req = TIMEOUT; exp_err = 1'b1;
      exp_rdata = w ? model_rdata : 32'hDEADBEEF;
    end
    exp_first = (exp_req > 0) ? 1 : -1;
    model_rdata = exp_rdata;

    bus.cs = c; bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = wd; bus.mem_ack = 1'b0;
    done = 0; cyc = 0; stall_cnt = 0; req_cnt = 0; first_req = -1; err_early = 0;
    got_err = 1'b0; got_rdata = '0;
    while (!done && cyc < MAX_CYC) begin
      #1;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
        checks++;
        if (bus.mem_addr !== exp_addr || bus.mem_we !== w || bus.mem_wdata !== wd) begin
          failures++;
          $display("FAIL %s bus_hold cyc%0d: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   name, cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, exp_addr, w, wd);
        end
        if (eff >= 0 && req_cnt == eff + 1) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = ack_data;
        end
      end
      if (bus.stall) begin
        stall_cnt++;
        if (bus.err) err_early++;
      end else begin
        done = 1;
        got_err = bus.err;
        got_rdata = bus.rdata;
        if (ack_in_done) bus.mem_ack = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_ack = 1'b0;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s completion: got no completion in %0d cycles expected completion", name, MAX_CYC);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (req_cnt != exp_req) begin
      failures++;
      $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cnt, exp_req);
    end
    checks++;
    if (first_req != exp_first) begin
      failures++;
      $display("FAIL %s req_start_cycle: got %0d expected %0d", name, first_req, exp_first);
    end
    checks++;
    if (err_early != 0) begin
      failures++;
      $display("FAIL %s err_while_stalled: got %0d cycles expected 0", name, err_early);
    end
    checks++;
    if (got_err !== exp_err) begin
      failures++;
      $display("FAIL %s err_at_done: got %b expected %b", name, got_err, exp_err);
    end
    checks++;
    if (got_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL %s rdata: got %h expected %h", name, got_rdata, exp_rdata);
    end
  endtask

  // Idle-state snapshot check used after reset and ignored acks.
  task automatic check_idle(input string name, input logic exp_stall_v, input logic [DATA_W-1:0] exp_rd,
                            input bit check_bus_zero);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.err !== 1'b0 || bus.stall !== exp_stall_v || bus.rdata !== exp_rd) begin
      failures++;
      $display("FAIL %s idle_outputs: got req=%b err=%b stall=%b rdata=%h expected req=0 err=0 stall=%b rdata=%h",
               name, bus.mem_req, bus.err, bus.stall, bus.rdata, exp_stall_v, exp_rd);
    end
    if (check_bus_zero) begin
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
        failures++;
        $display("FAIL %s bus_cleared: got we=%b addr=%h wdata=%h expected all zero",
                 name, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 32'h10;
    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset_access", 1'b1, '0, 1'b1);
    bus.cs = 1'b0; bus.rd = 1'b0; bus.mem_ack = 1'b0;
    #1;
    check_idle("reset_noaccess", 1'b0, '0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_rdata = '0;
  endtask

  task automatic test_idle_ack();
    bus.cs = 1'b0; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      @(negedge clk);
      #1;
      check_idle("idle_ack", 1'b0, model_rdata, 1'b0);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    do_access("cs_no_strobe", 1'b1, 1'b0, 1'b0, 32'h48, 32'h1, 0, 32'h5, 1'b0);
  endtask

  task automatic test_aligned_read();
    do_access("aligned_read", 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_write_wait();
    do_access("write_wait", 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2, 32'hBAD0_BAD0, 1'b0);
  endtask

  task automatic test_misaligned();
    do_access("misaligned_load", 1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h5555_AAAA, 1'b0);
    do_access("misaligned_store", 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h7, 0, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_timeout();
    do_access("ack_last_cycle", 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D, 1'b0);
    do_access("timeout_read", 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, -1, 32'h0, 1'b1);
    #1;
    check_idle("late_ack_done", 1'b0, model_rdata, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check_idle("late_ack_idle", 1'b0, model_rdata, 1'b0);
    @(negedge clk);
    do_access("timeout_write", 1'b1, 1'b0, 1'b1, 32'h0000_0050, 32'h9, -1, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 32'h100; bus.wdata = 32'h77;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy_precheck: got req=%b stall=%b expected req=1 stall=1", bus.mem_req, bus.stall);
    end
    reset = 1'b0;
    bus.cs = 1'b0; bus.rd = 1'b0;
    @(negedge clk);
    #1;
    model_rdata = '0;
    check_idle("rst_busy", 1'b0, '0, 1'b1);
    reset = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check_idle("rst_busy_late_ack", 1'b0, '0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_rdwr_write", 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_0001, 0, 32'hDEAD_0000, 1'b0);
    do_access("b2b_read", 1'b1, 1'b1, 1'b0, 32'h0000_0084, 32'h0, 1, 32'h0C0F_FEE0, 1'b0);
    do_access("b2b_write2", 1'b1, 1'b0, 1'b1, 32'h0000_0088, 32'h1357_9BDF, 0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [ADDR_W-1:0] a;
      logic r, w;
      int sel, ack;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      sel = $urandom_range(0, 2);
      r = (sel != 1);
      w = (sel != 0);
      sel = $urandom_range(0, 9);
      if (sel == 0) ack = -1;
      else if (sel == 1) ack = TIMEOUT - 1 + $urandom_range(0, 2);
      else ack = $urandom_range(0, 5);
      do_access($sformatf("rand%0d", i), 1'b1, r, w, a, $urandom, ack, $urandom, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_idle_ack();
    test_aligned_read();
    test_write_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle core's data port (cs/rd/wr/addr/wdata) and upstream of a slow external data memory with a req/ack handshake.
- Converts each core access into a multi-cycle handshake and stalls the core until the access completes.
- Returns read data on the core's memory-read-data input.
- Flags misaligned accesses and memory timeouts.

Parameters:
- ADDR_W, 32, core address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max BUSY cycles without ack before abort (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cs  in  1  core data-memory chip select.
- rd  in  1  core read strobe.
- wr  in  1  core write strobe.
- addr  in  ADDR_W  core byte address (ALU result).
- wdata  in  DATA_W  core store data.
- rdata  out  DATA_W  load data to core; registered.
- stall  out  1  freeze core PC/regfile write while high.
- err  out  1  one-cycle pulse: misaligned access or timeout.
- mem_req  out  1  request to memory; registered.
- mem_we  out  1  1 = write, 0 = read; registered.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}; registered.
- mem_wdata  out  DATA_W  registered store data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  valid when mem_ack=1 on a read.

Behaviour:
- access = cs & (rd | wr). When rd and wr are both high, the access is a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No access: stay in IDLE.
  - Access with addr[1:0] != 0: go to DONE, no request issued, err pulses in DONE, rdata unchanged.
  - Aligned access: latch mem_addr, mem_wdata and mem_we; set mem_req=1; clear the timeout counter; go to BUSY.
- BUSY:
  - mem_req stays high.
  - mem_ack=1: drop mem_req. On a read, capture mem_rdata into rdata. Go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack: drop mem_req, set rdata=32'hDEADBEEF on a read (unchanged on a write), pulse err in DONE, go to DONE.
- DONE: unconditionally return to IDLE.
  - The core completes the instruction in this cycle and presents the next one.
- stall (combinational) = (state==IDLE & access) | (state==BUSY). It is 0 in DONE.
- err is high only in DONE, and only when entered via misalignment or timeout.
- Latency: ack in the first BUSY cycle gives a 3-cycle instruction with stall high for 2 cycles. Each extra wait cycle adds 1.
- mem_ack seen in IDLE or DONE is ignored; no state or rdata change.
- mem_addr, mem_wdata and mem_we are stable for the whole time mem_req is high. Core inputs are sampled only on the IDLE->BUSY transition.
- Reset (reset=0 at a rising edge, including mid-BUSY):
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, err=0, counter=0.
  - stall follows its combinational rule from IDLE.
  - An ack arriving after reset is ignored.
- Back-to-back accesses: DONE->IDLE, then a new access is detected in IDLE with stall asserted immediately. There is no bubble on mem_req beyond one IDLE cycle.
- Counter width is clog2(TIMEOUT). No wrap occurs because the timeout forces exit from BUSY.

Test Plan:
- Aligned read: addr=0x0000_0010, ack in 1st BUSY cycle with mem_rdata=0x1234_5678 -> mem_addr=0x10, mem_we=0, stall high for 2 cycles, rdata=0x1234_5678 in DONE, err=0.
- Write with wait states: wr=1, addr=0x20, wdata=0xCAFEF00D, ack after 3 BUSY cycles -> mem_we=1, mem_wdata=0xCAFEF00D stable while mem_req=1, stall high for 4 cycles, rdata unchanged.
- Misaligned load: addr=0x0000_0013, rd=1 -> mem_req never rises, 1 stall cycle, err pulses in DONE.
- Timeout with TIMEOUT=16: read, never ack -> mem_req high for exactly 16 cycles, rdata=0xDEADBEEF, err pulse; a late ack is then ignored.
- Reset mid-BUSY: assert reset=0 on the 2nd BUSY cycle -> next edge gives mem_req=0, rdata=0, state IDLE; an ack one cycle later does not change rdata.
- rd & wr both high plus back-to-back: write then read on consecutive instructions -> first access is a write, the second request starts 2 cycles after the first DONE, and stall has no gap in IDLE.
